uart_tx_feeder: RTL and testbench

// - Byte FIFO plus launch FSM directly upstream of uart_tx. Accepts bytes from the host/packet logic at
//   up to one per clock and sequences them into uart_tx one frame at a time via i_Tx_DV/i_Tx_Byte.
// - Paces launches using o_Tx_Active/o_Tx_Done. uart_tx has no reset, so it never issues a pulse that

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx_feeder.sv | 124 ++++++++++++
 tb/tb_uart_tx_feeder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART byte width and feeder FSM state encoding
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        s_IDLE        = 3'd0,
        s_LAUNCH      = 3'd1,
        s_WAIT_ACTIVE = 3'd2,
        s_WAIT_DONE   = 3'd3,
        s_GAP         = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with occupancy, full/empty and overflow pulse
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Pointers carry one extra bit so full and empty differ while the index bits match.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == FULL_COUNT);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and launch sequencer in front of uart_tx
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int IDLE_GAP_CLKS = 0
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Wr_DV,
    input  logic [BYTE_W-1:0]      i_Wr_Byte,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [$clog2(DEPTH):0] o_Count,
    output logic                   o_Overflow,
    output logic                   o_Busy,
    output logic                   o_Tx_DV,
    output logic [BYTE_W-1:0]      o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done
);

    localparam logic [7:0] GAP_LAST = 8'(IDLE_GAP_CLKS);

    feeder_state_t     state;
    feeder_state_t     state_next;
    logic [1:0]        rst_sync;
    logic              rst_int;
    logic              pop;
    logic              gap_clr;
    logic              gap_inc;
    logic [7:0]        gap_cnt;
    logic [BYTE_W-1:0] head;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end
    assign rst_int = rst_sync[1];

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (i_Clock),
        .rst      (rst_int),
        .wr_en    (i_Wr_DV),
        .wr_data  (i_Wr_Byte),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (o_Full),
        .empty    (o_Empty),
        .count    (o_Count),
        .overflow (o_Overflow)
    );

    assign o_Busy = (state != s_IDLE) || !o_Empty;

    always_ff @(posedge i_Clock or posedge rst_int) begin
        if (rst_int) begin
            state     <= s_IDLE;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= '0;
            gap_cnt   <= '0;
        end else begin
            state   <= state_next;
            o_Tx_DV <= pop;
            if (pop) begin
                o_Tx_Byte <= head;
            end
            if (gap_clr) begin
                gap_cnt <= '0;
            end else if (gap_inc) begin
                gap_cnt <= gap_cnt + 8'd1;
            end
        end
    end

    // Launch only when uart_tx is truly idle so its DV sample can never be missed.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        gap_clr    = 1'b0;
        gap_inc    = 1'b0;
        case (state)
            s_IDLE: begin
                if (!o_Empty && !i_Tx_Active && !i_Tx_Done) begin
                    pop        = 1'b1;
                    state_next = s_LAUNCH;
                end
            end
            s_LAUNCH: begin
                state_next = s_WAIT_ACTIVE;
            end
            s_WAIT_ACTIVE: begin
                if (i_Tx_Active) begin
                    state_next = s_WAIT_DONE;
                end
            end
            s_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    gap_clr    = 1'b1;
                    state_next = s_GAP;
                end
            end
            s_GAP: begin
                if (i_Tx_Done) begin
                    gap_clr = 1'b1;
                end else if (gap_cnt == GAP_LAST) begin
                    state_next = s_IDLE;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            default: begin
                state_next = s_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed bench for uart_tx_feeder with a uart_tx model and line decoder
module tb_uart_tx_feeder;

    localparam int CPB = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_dv0, wr_dv1;
    logic [7:0] wr_byte0, wr_byte1;
    logic       full0, empty0, ovf0, busy0, tx_dv0;
    logic       full1, empty1, ovf1, busy1, tx_dv1;
    logic [4:0] count0, count1;
    logic [7:0] tx_byte0, tx_byte1;

    logic [1:0] tx_active = 2'b00;
    logic [1:0] tx_done   = 2'b00;
    logic [1:0] tx_serial = 2'b11;
    int         m_state [2] = '{0, 0};
    int         m_cnt   [2] = '{0, 0};
    int         m_bit   [2] = '{0, 0};
    logic [7:0] m_byte  [2];

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    int         dv_cnt0 = 0;
    int         dv_cnt1 = 0;
    int         ovf_cnt0 = 0;
    int         last_fall [2] = '{0, 0};
    logic [1:0] done_prev = 2'b00;
    int         gap_q0 [$];
    int         gap_q1 [$];
    logic [7:0] rx_q [$];
    logic [7:0] rx_b;
    int         dv_base, gq_base;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(16), .IDLE_GAP_CLKS(0)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Wr_DV(wr_dv0), .i_Wr_Byte(wr_byte0),
        .o_Full(full0), .o_Empty(empty0), .o_Count(count0), .o_Overflow(ovf0),
        .o_Busy(busy0), .o_Tx_DV(tx_dv0), .o_Tx_Byte(tx_byte0),
        .i_Tx_Active(tx_active[0]), .i_Tx_Done(tx_done[0])
    );

    uart_tx_feeder #(.DEPTH(16), .IDLE_GAP_CLKS(5)) dut_gap (
        .i_Clock(clk), .i_Reset(rst), .i_Wr_DV(wr_dv1), .i_Wr_Byte(wr_byte1),
        .o_Full(full1), .o_Empty(empty1), .o_Count(count1), .o_Overflow(ovf1),
        .o_Busy(busy1), .o_Tx_DV(tx_dv1), .o_Tx_Byte(tx_byte1),
        .i_Tx_Active(tx_active[1]), .i_Tx_Done(tx_done[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // uart_tx model: no reset, Done high for two clocks, Active drops with Done rising.
    always @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            case (m_state[ch])
                0: begin
                    tx_serial[ch] <= 1'b1;
                    tx_done[ch]   <= 1'b0;
                    m_cnt[ch]     <= 0;
                    m_bit[ch]     <= 0;
                    if ((ch == 0) ? tx_dv0 : tx_dv1) begin
                        tx_active[ch] <= 1'b1;
                        m_byte[ch]    <= (ch == 0) ? tx_byte0 : tx_byte1;
                        m_state[ch]   <= 1;
                    end
                end
                1: begin
                    tx_serial[ch] <= 1'b0;
                    if (m_cnt[ch] < CPB - 1) m_cnt[ch] <= m_cnt[ch] + 1;
                    else begin m_cnt[ch] <= 0; m_state[ch] <= 2; end
                end
                2: begin
                    tx_serial[ch] <= m_byte[ch][m_bit[ch]];
                    if (m_cnt[ch] < CPB - 1) m_cnt[ch] <= m_cnt[ch] + 1;
                    else begin
                        m_cnt[ch] <= 0;
                        if (m_bit[ch] < 7) m_bit[ch] <= m_bit[ch] + 1;
                        else begin m_bit[ch] <= 0; m_state[ch] <= 3; end
                    end
                end
                3: begin
                    tx_serial[ch] <= 1'b1;
                    if (m_cnt[ch] < CPB - 1) m_cnt[ch] <= m_cnt[ch] + 1;
                    else begin
                        m_cnt[ch]     <= 0;
                        tx_done[ch]   <= 1'b1;
                        tx_active[ch] <= 1'b0;
                        m_state[ch]   <= 4;
                    end
                end
                default: begin
                    tx_done[ch] <= 1'b1;
                    m_state[ch] <= 0;
                end
            endcase
        end
    end

    // Serial decoder on channel 0: each bit lasts two clocks.
    always begin
        @(negedge clk);
        if (tx_serial[0] == 1'b0) begin
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                rx_b[i] = tx_serial[0];
                repeat (2) @(negedge clk);
            end
            check_val("stop_bit", {31'b0, tx_serial[0]}, 1);
            rx_q.push_back(rx_b);
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int ch = 0; ch < 2; ch++) begin
            if (done_prev[ch] && !tx_done[ch]) last_fall[ch] = cyc;
        end
        done_prev = tx_done;
        if (ovf0) ovf_cnt0++;
        if (tx_dv0) begin
            dv_cnt0++;
            gap_q0.push_back(cyc - last_fall[0]);
            check_val("dv_while_tx_idle0",
                      (tx_active[0] || tx_done[0] || m_state[0] != 0) ? 32'd1 : 32'd0, 0);
        end
        if (tx_dv1) begin
            dv_cnt1++;
            gap_q1.push_back(cyc - last_fall[1]);
            check_val("dv_while_tx_idle1",
                      (tx_active[1] || tx_done[1] || m_state[1] != 0) ? 32'd1 : 32'd0, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain0(input int n_rx, input int budget);
        int i;
        i = 0;
        while ((rx_q.size() < n_rx || busy0) && i < budget) begin
            tick();
            i++;
        end
        check_val("drain0_in_budget", (i < budget) ? 32'd1 : 32'd0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wr_dv0 = 1'b0; wr_byte0 = 8'h00;
        wr_dv1 = 1'b0; wr_byte1 = 8'h00;
        repeat (3) tick();

        check_val("rst_tx_dv", {31'b0, tx_dv0}, 0);
        check_val("rst_tx_byte", {24'b0, tx_byte0}, 8'h00);
        check_val("rst_empty", {31'b0, empty0}, 1);
        check_val("rst_full", {31'b0, full0}, 0);
        check_val("rst_count", {27'b0, count0}, 0);
        check_val("rst_overflow", {31'b0, ovf0}, 0);
        check_val("rst_busy", {31'b0, busy0}, 0);

        rst = 1'b0;
        repeat (20) tick();
        check_val("idle_empty", {31'b0, empty0}, 1);
        check_val("idle_no_dv", dv_cnt0, 0);
        check_val("idle_line_high", {31'b0, tx_serial[0]}, 1);

        // Single byte: DV two clocks after the write cycle.
        wr_dv0 = 1'b1; wr_byte0 = 8'hA5;
        tick();
        wr_dv0 = 1'b0;
        check_val("a5_count", {27'b0, count0}, 1);
        check_val("a5_dv_early", {31'b0, tx_dv0}, 0);
        tick();
        check_val("a5_dv", {31'b0, tx_dv0}, 1);
        check_val("a5_tx_byte", {24'b0, tx_byte0}, 8'hA5);
        tick();
        check_val("a5_dv_pulse_end", {31'b0, tx_dv0}, 0);
        drain0(1, 200);
        check_val("a5_rx_count", rx_q.size(), 1);
        check_val("a5_rx_byte", {24'b0, rx_q[0]}, 8'hA5);
        check_val("a5_busy_after", {31'b0, busy0}, 0);
        check_val("a5_dv_total", dv_cnt0, 1);
        rx_q.delete();

        // Keep uart_tx busy with 0x55 while a 16-byte burst fills the FIFO.
        wr_dv0 = 1'b1; wr_byte0 = 8'h55;
        tick();
        wr_dv0 = 1'b0;
        for (int i = 0; i < 10 && !tx_dv0; i++) tick();
        check_val("burst_lead_dv", {31'b0, tx_dv0}, 1);
        tick();
        dv_base = dv_cnt0;
        gq_base = gap_q0.size();
        for (int i = 0; i < 16; i++) begin
            wr_dv0 = 1'b1; wr_byte0 = 8'(i);
            if (i < 15) tick();
            else begin
                tick();
            end
        end
        check_val("burst_full", {31'b0, full0}, 1);
        check_val("burst_count", {27'b0, count0}, 16);
        check_val("burst_no_overflow", ovf_cnt0, 0);
        wr_byte0 = 8'hFF;
        tick();
        wr_dv0 = 1'b0;
        check_val("ovf_pulse", {31'b0, ovf0}, 1);
        check_val("ovf_count_held", {27'b0, count0}, 16);
        tick();
        check_val("ovf_pulse_end", {31'b0, ovf0}, 0);
        check_val("ovf_pulses", ovf_cnt0, 1);
        drain0(17, 1500);
        check_val("burst_rx_count", rx_q.size(), 17);
        check_val("burst_rx_lead", {24'b0, rx_q[0]}, 8'h55);
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("burst_rx_%0d", i), {24'b0, rx_q[i + 1]}, i);
            check_val($sformatf("burst_gap_%0d", i), gap_q0[gq_base + i], 2);
        end
        check_val("burst_dv_pulses", dv_cnt0 - dv_base, 16);
        rx_q.delete();

        // Five-clock idle gap on the second instance.
        wr_dv1 = 1'b1; wr_byte1 = 8'h3C;
        tick();
        wr_byte1 = 8'hC3;
        tick();
        wr_dv1 = 1'b0;
        for (int i = 0; i < 200 && busy1; i++) tick();
        check_val("gap5_idle", {31'b0, busy1}, 0);
        check_val("gap5_dv_count", dv_cnt1, 2);
        check_val("gap5_clks", gap_q1.size() >= 2 ? gap_q1[1] : -1, 7);

        // Reset mid-frame with four bytes still queued.
        for (int i = 0; i < 5; i++) begin
            wr_dv0 = 1'b1; wr_byte0 = 8'h31 + 8'(i);
            tick();
        end
        wr_dv0 = 1'b0;
        repeat (6) tick();
        check_val("mid_queued", {27'b0, count0}, 4);
        check_val("mid_active", {31'b0, tx_active[0]}, 1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_count", {27'b0, count0}, 0);
        check_val("mid_rst_empty", {31'b0, empty0}, 1);
        repeat (2) tick();
        rst = 1'b0;
        dv_base = dv_cnt0;
        repeat (8) tick();
        check_val("post_rst_no_dv", dv_cnt0 - dv_base, 0);
        check_val("post_rst_frame_running", {31'b0, tx_active[0]}, 1);
        wr_dv0 = 1'b1; wr_byte0 = 8'h77;
        tick();
        wr_dv0 = 1'b0;
        drain0(2, 400);
        check_val("post_rst_rx_count", rx_q.size(), 2);
        check_val("post_rst_rx0", {24'b0, rx_q[0]}, 8'h31);
        check_val("post_rst_rx1", {24'b0, rx_q[1]}, 8'h77);
        check_val("post_rst_dv_pulses", dv_cnt0 - dv_base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
